// File: rtl/mem_stage_v_pkg.sv
// Shared constants and types for the MEM pipeline stage.
package mem_stage_v_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned RD_W  = 5;
  localparam int unsigned CNT_W = 16;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [XLEN-1:0] MEM_ERR_DATA = 32'hDEADBEEF;

  // EX/MEM slot contents, held for the duration of a memory access
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [RD_W-1:0] rd;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] store_data;
  } ex_slot_t;

endpackage

// File: rtl/mem_stage_v_if.sv
// Data-memory request/ready/rvalid bus between the MEM stage and memory.
interface mem_stage_v_if;
  import mem_stage_v_pkg::*;

  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic [3:0]      dmem_be;
  logic            dmem_ready;
  logic            dmem_rvalid;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ready, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ready, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_stage_v_align.sv
// Store lane replication / byte enables, load lane extract / extension,
// and detection of misaligned or illegal-funct3 memory operations.
module mem_align_v
  import mem_stage_v_pkg::*;
(
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lo_i,
  input  logic            mem_read_i,
  input  logic            mem_write_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] wdata_o,
  output logic [3:0]      be_o,
  output logic [XLEN-1:0] load_data_o,
  output logic            bad_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    wdata_o     = store_data_i;
    be_o        = 4'b0000;
    load_data_o = '0;
    bad_o       = 1'b0;

    case (addr_lo_i)
      2'd0:    byte_v = rdata_i[7:0];
      2'd1:    byte_v = rdata_i[15:8];
      2'd2:    byte_v = rdata_i[23:16];
      default: byte_v = rdata_i[31:24];
    endcase
    half_v = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    // An instruction claiming to both load and store is treated as illegal
    if (mem_read_i && mem_write_i) begin
      bad_o = 1'b1;
    end else if (mem_read_i) begin
      case (funct3_i)
        F3_B:    load_data_o = {{24{byte_v[7]}}, byte_v};
        F3_BU:   load_data_o = {24'd0, byte_v};
        F3_H: begin
          load_data_o = {{16{half_v[15]}}, half_v};
          bad_o       = addr_lo_i[0];
        end
        F3_HU: begin
          load_data_o = {16'd0, half_v};
          bad_o       = addr_lo_i[0];
        end
        F3_W: begin
          load_data_o = rdata_i;
          bad_o       = (addr_lo_i != 2'd0);
        end
        default: bad_o = 1'b1;
      endcase
    end else if (mem_write_i) begin
      case (funct3_i)
        F3_B: begin
          wdata_o = {4{store_data_i[7:0]}};
          be_o    = 4'b0001 << addr_lo_i;
        end
        F3_H: begin
          wdata_o = {2{store_data_i[15:0]}};
          be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
          bad_o   = addr_lo_i[0];
        end
        F3_W: begin
          be_o  = 4'b1111;
          bad_o = (addr_lo_i != 2'd0);
        end
        default: bad_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/mem_stage_v.sv
// Pipeline MEM stage: ALU pass-through, variable-latency data-memory access
// with upstream stall, lane alignment and a watchdog on stuck accesses.
module mem_stage_v
  import mem_stage_v_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              ex_isValid,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic [XLEN-1:0]   ex_instr,
  input  logic [RD_W-1:0]   ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_reg_write,
  input  logic [XLEN-1:0]   ex_aluResult,
  input  logic [XLEN-1:0]   ex_storeData,

  output logic              mem_stall,
  mem_stage_v_if.master     dmem,

  output logic              mem_isValid,
  output logic [XLEN-1:0]   mem_pc,
  output logic [XLEN-1:0]   mem_instr,
  output logic [RD_W-1:0]   mem_rd,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic              mem_reg_write,
  output logic [XLEN-1:0]   mem_aluResult,
  output logic [XLEN-1:0]   mem_memResult,
  output logic              mem_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  ex_slot_t         slot_q, slot_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  ex_slot_t         ex_slot;
  ex_slot_t         sel_slot;
  logic [XLEN-1:0]  al_wdata;
  logic [3:0]       al_be;
  logic [XLEN-1:0]  al_load;
  logic             al_bad;
  logic             expire;
  logic [CNT_W-1:0] cnt_inc;

  logic             bus_req;
  logic             out_valid;
  logic             out_err;
  logic [XLEN-1:0]  out_result;

  // In IDLE everything comes straight from EX/MEM; otherwise from the latch
  always_comb begin
    ex_slot.pc         = ex_pc;
    ex_slot.instr      = ex_instr;
    ex_slot.rd         = ex_rd;
    ex_slot.mem_read   = ex_mem_read;
    ex_slot.mem_write  = ex_mem_write;
    ex_slot.reg_write  = ex_reg_write;
    ex_slot.alu        = ex_aluResult;
    ex_slot.store_data = ex_storeData;
    sel_slot           = (state_q == ST_IDLE) ? ex_slot : slot_q;
  end

  mem_align_v u_align (
    .funct3_i     (sel_slot.instr[14:12]),
    .addr_lo_i    (sel_slot.alu[1:0]),
    .mem_read_i   (sel_slot.mem_read),
    .mem_write_i  (sel_slot.mem_write),
    .store_data_i (sel_slot.store_data),
    .rdata_i      (dmem.dmem_rdata),
    .wdata_o      (al_wdata),
    .be_o         (al_be),
    .load_data_o  (al_load),
    .bad_o        (al_bad)
  );

  assign expire  = (cnt_q == CNT_LAST);
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      slot_q   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      result_q <= result_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    result_d   = result_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    mem_stall  = 1'b0;
    bus_req    = 1'b0;
    out_valid  = 1'b0;
    out_err    = 1'b0;
    out_result = '0;

    case (state_q)
      ST_IDLE: begin
        if (ex_isValid) begin
          if (!ex_mem_read && !ex_mem_write) begin
            out_valid = 1'b1;
          end else if (al_bad) begin
            out_valid = 1'b1;
            out_err   = 1'b1;
          end else begin
            mem_stall = 1'b1;
            bus_req   = 1'b1;
            slot_d    = ex_slot;
            result_d  = '0;
            err_d     = 1'b0;
            cnt_d     = '0;
            state_d   = dmem.dmem_ready ? ST_WAIT : ST_REQ;
          end
        end
      end
      ST_REQ: begin
        mem_stall = 1'b1;
        cnt_d     = cnt_inc;
        // Request is withdrawn in the expiring cycle so it cannot be accepted
        if (expire) begin
          err_d    = 1'b1;
          result_d = MEM_ERR_DATA;
          state_d  = ST_DONE;
        end else begin
          bus_req = 1'b1;
          if (dmem.dmem_ready) state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        mem_stall = 1'b1;
        cnt_d     = cnt_inc;
        if (dmem.dmem_rvalid) begin
          result_d = slot_q.mem_read ? al_load : '0;
          state_d  = ST_DONE;
        end else if (expire) begin
          err_d    = 1'b1;
          result_d = MEM_ERR_DATA;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid  = 1'b1;
        out_err    = err_q;
        out_result = result_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    dmem.dmem_req   = bus_req;
    dmem.dmem_we    = bus_req & sel_slot.mem_write;
    dmem.dmem_addr  = bus_req ? {sel_slot.alu[XLEN-1:2], 2'b00} : '0;
    dmem.dmem_wdata = bus_req ? al_wdata : '0;
    dmem.dmem_be    = bus_req ? al_be : 4'b0000;

    mem_isValid   = out_valid;
    mem_pc        = out_valid ? sel_slot.pc : '0;
    mem_instr     = out_valid ? sel_slot.instr : '0;
    mem_rd        = out_valid ? sel_slot.rd : '0;
    mem_mem_read  = out_valid & sel_slot.mem_read;
    mem_mem_write = out_valid & sel_slot.mem_write;
    mem_reg_write = out_valid & sel_slot.reg_write & ~out_err;
    mem_aluResult = out_valid ? sel_slot.alu : '0;
    mem_memResult = out_result;
    mem_err       = out_valid & out_err;
  end

endmodule

// File: tb/tb_mem_stage_v.sv
// Self-checking bench for mem_stage_v: same-cycle vector table plus
// multi-cycle load/store/timeout/reset sequences with a completion scoreboard.
module tb_mem_stage_v;
  import mem_stage_v_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] alu;
    logic [31:0] memres;
    logic [4:0]  rd;
    logic        rw;
    logic        err;
    logic        mr;
    logic        mw;
  } exp_t;

  typedef struct {
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        mr;
    logic        mw;
    logic        rw;
    logic [31:0] alu;
    logic [31:0] sd;
    logic        exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_isValid;
  logic [31:0] ex_pc, ex_instr, ex_aluResult, ex_storeData;
  logic [4:0]  ex_rd;
  logic        ex_mem_read, ex_mem_write, ex_reg_write;
  logic        mem_stall, mem_isValid;
  logic [31:0] mem_pc, mem_instr, mem_aluResult, mem_memResult;
  logic [4:0]  mem_rd;
  logic        mem_mem_read, mem_mem_write, mem_reg_write, mem_err;

  mem_stage_v_if bus ();

  mem_stage_v #(.TIMEOUT_CYCLES(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .ex_isValid    (ex_isValid),
    .ex_pc         (ex_pc),
    .ex_instr      (ex_instr),
    .ex_rd         (ex_rd),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_reg_write  (ex_reg_write),
    .ex_aluResult  (ex_aluResult),
    .ex_storeData  (ex_storeData),
    .mem_stall     (mem_stall),
    .dmem          (bus),
    .mem_isValid   (mem_isValid),
    .mem_pc        (mem_pc),
    .mem_instr     (mem_instr),
    .mem_rd        (mem_rd),
    .mem_mem_read  (mem_mem_read),
    .mem_mem_write (mem_mem_write),
    .mem_reg_write (mem_reg_write),
    .mem_aluResult (mem_aluResult),
    .mem_memResult (mem_memResult),
    .mem_err       (mem_err)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb_q[$];
  vec_t vt[11];

  function automatic logic [31:0] mk_instr(input logic [2:0] f3);
    return {17'd0, f3, 12'h003};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_cyc(input string tag, input logic st, input logic rq, input logic vl);
    chk({tag, "_stall"}, 32'(mem_stall), 32'(st));
    chk({tag, "_req"}, 32'(bus.dmem_req), 32'(rq));
    chk({tag, "_valid"}, 32'(mem_isValid), 32'(vl));
  endtask

  // Pops the scoreboard on every completion strobe
  task automatic monitor();
    exp_t act, e;
    act = '{mem_pc, mem_instr, mem_aluResult, mem_memResult, mem_rd,
            mem_reg_write, mem_err, mem_mem_read, mem_mem_write};
    if (mem_isValid === 1'b1) begin
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL completion: unexpected mem_isValid, got %h", act);
      end else begin
        e = sb_q.pop_front();
        if (act !== e) begin
          n_err++;
          $display("FAIL completion: got %h expected %h", act, e);
        end
      end
    end
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic adv();
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic [31:0] pc, input logic [2:0] f3, input logic [4:0] rd,
                          input logic mr, input logic mw, input logic rw,
                          input logic [31:0] alu, input logic [31:0] sd);
    ex_isValid   = 1'b1;
    ex_pc        = pc;
    ex_instr     = mk_instr(f3);
    ex_rd        = rd;
    ex_mem_read  = mr;
    ex_mem_write = mw;
    ex_reg_write = rw;
    ex_aluResult = alu;
    ex_storeData = sd;
  endtask

  task automatic idle_ex();
    ex_isValid   = 1'b0;
    ex_pc        = '0;
    ex_instr     = '0;
    ex_rd        = '0;
    ex_mem_read  = 1'b0;
    ex_mem_write = 1'b0;
    ex_reg_write = 1'b0;
    ex_aluResult = '0;
    ex_storeData = '0;
  endtask

  task automatic load_seq(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [31:0] exp);
    drive_ex(32'h2000, f3, 5'd9, 1'b1, 1'b0, 1'b1, addr, 32'h0);
    bus.dmem_ready = 1'b1;
    sb_q.push_back('{32'h2000, mk_instr(f3), addr, exp, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0});
    settle(); exp_cyc({tag, "_c0"}, 1, 1, 0);
    chk({tag, "_addr"}, bus.dmem_addr, addr & ~32'h3);
    chk({tag, "_we"}, 32'(bus.dmem_we), 32'h0);
    adv();
    bus.dmem_ready = 1'b0; bus.dmem_rvalid = 1'b1; bus.dmem_rdata = rdata;
    settle(); exp_cyc({tag, "_c1"}, 1, 0, 0); adv();
    bus.dmem_rvalid = 1'b0; bus.dmem_rdata = '0;
    settle(); exp_cyc({tag, "_c2"}, 0, 0, 1); adv();
    idle_ex();
    settle(); exp_cyc({tag, "_c3"}, 0, 0, 0); adv();
  endtask

  task automatic store_seq(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] sd, input int delay,
                           input logic [31:0] exp_wdata, input logic [3:0] exp_be);
    drive_ex(32'h3000, f3, 5'd0, 1'b0, 1'b1, 1'b0, addr, sd);
    sb_q.push_back('{32'h3000, mk_instr(f3), addr, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1});
    for (int c = 0; c <= delay; c++) begin
      bus.dmem_ready = (c == delay);
      settle(); exp_cyc($sformatf("%s_req%0d", tag, c), 1, 1, 0);
      chk({tag, "_addr"}, bus.dmem_addr, addr & ~32'h3);
      chk({tag, "_we"}, 32'(bus.dmem_we), 32'h1);
      chk({tag, "_wdata"}, bus.dmem_wdata, exp_wdata);
      chk({tag, "_be"}, 32'(bus.dmem_be), 32'(exp_be));
      adv();
    end
    bus.dmem_ready = 1'b0; bus.dmem_rvalid = 1'b1;
    settle(); exp_cyc({tag, "_ack"}, 1, 0, 0); adv();
    bus.dmem_rvalid = 1'b0;
    settle(); exp_cyc({tag, "_done"}, 0, 0, 1); adv();
    idle_ex();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{f3: 3'b000, rd: 5'd5,  mr: 0, mw: 0, rw: 1, alu: 32'h10,       sd: 32'h0,  exp_err: 0};
    vt[1]  = '{f3: 3'b010, rd: 5'd31, mr: 0, mw: 0, rw: 0, alu: 32'hFFFFFFFF, sd: 32'h0,  exp_err: 0};
    vt[2]  = '{f3: F3_W,   rd: 5'd6,  mr: 1, mw: 0, rw: 1, alu: 32'h101,      sd: 32'h0,  exp_err: 1};
    vt[3]  = '{f3: F3_H,   rd: 5'd7,  mr: 1, mw: 0, rw: 1, alu: 32'h103,      sd: 32'h0,  exp_err: 1};
    vt[4]  = '{f3: F3_HU,  rd: 5'd7,  mr: 1, mw: 0, rw: 1, alu: 32'h201,      sd: 32'h0,  exp_err: 1};
    vt[5]  = '{f3: F3_W,   rd: 5'd0,  mr: 0, mw: 1, rw: 0, alu: 32'h102,      sd: 32'hAA, exp_err: 1};
    vt[6]  = '{f3: F3_H,   rd: 5'd0,  mr: 0, mw: 1, rw: 0, alu: 32'h101,      sd: 32'h0,  exp_err: 1};
    vt[7]  = '{f3: 3'b011, rd: 5'd8,  mr: 1, mw: 0, rw: 1, alu: 32'h100,      sd: 32'h0,  exp_err: 1};
    vt[8]  = '{f3: 3'b100, rd: 5'd0,  mr: 0, mw: 1, rw: 0, alu: 32'h100,      sd: 32'h0,  exp_err: 1};
    vt[9]  = '{f3: 3'b110, rd: 5'd1,  mr: 1, mw: 0, rw: 1, alu: 32'h100,      sd: 32'h0,  exp_err: 1};
    vt[10] = '{f3: 3'b111, rd: 5'd0,  mr: 0, mw: 0, rw: 1, alu: 32'h80000000, sd: 32'h0,  exp_err: 0};

    reset = 1'b1;
    idle_ex();
    bus.dmem_ready = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    settle(); exp_cyc("rst", 0, 0, 0);
    chk("rst_addr", bus.dmem_addr, 32'h0);
    chk("rst_memres", mem_memResult, 32'h0);
    chk("rst_err", 32'(mem_err), 32'h0);
    reset = 1'b0;
    adv();

    // Same-cycle completions: ALU pass-through, misaligned and illegal ops
    for (int i = 0; i < 11; i++) begin
      drive_ex(32'h1000 + 32'(i * 4), vt[i].f3, vt[i].rd, vt[i].mr, vt[i].mw, vt[i].rw,
               vt[i].alu, vt[i].sd);
      sb_q.push_back('{32'h1000 + 32'(i * 4), mk_instr(vt[i].f3), vt[i].alu, 32'h0, vt[i].rd,
                       vt[i].rw & ~vt[i].exp_err, vt[i].exp_err, vt[i].mr, vt[i].mw});
      settle(); exp_cyc($sformatf("vec%0d", i), 0, 0, 1); adv();
    end
    idle_ex();

    load_seq("lb",  F3_B,  32'h103, 32'h80FFFFFF, 32'hFFFFFF80);
    load_seq("lbu", F3_BU, 32'h103, 32'h80FFFFFF, 32'h00000080);
    load_seq("lh",  F3_H,  32'h102, 32'h80FFFFFF, 32'hFFFF80FF);
    load_seq("lhu", F3_HU, 32'h102, 32'h80FFFFFF, 32'h000080FF);
    load_seq("lw",  F3_W,  32'h104, 32'h80FFFFFF, 32'h80FFFFFF);

    store_seq("sh", F3_H, 32'h102, 32'h1234ABCD, 2, 32'hABCDABCD, 4'b1100);
    store_seq("sb", F3_B, 32'h101, 32'h000000EF, 0, 32'hEFEFEFEF, 4'b0010);
    store_seq("sw", F3_W, 32'h108, 32'hCAFEF00D, 1, 32'hCAFEF00D, 4'b1111);

    // Watchdog: accepted load with no response
    drive_ex(32'h4000, F3_W, 5'd12, 1'b1, 1'b0, 1'b1, 32'h200, 32'h0);
    bus.dmem_ready = 1'b1;
    sb_q.push_back('{32'h4000, mk_instr(F3_W), 32'h200, MEM_ERR_DATA, 5'd12, 1'b0, 1'b1, 1'b1, 1'b0});
    settle(); exp_cyc("to_c0", 1, 1, 0); adv();
    bus.dmem_ready = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      settle(); exp_cyc($sformatf("to_c%0d", c), 1, 0, 0); adv();
    end
    settle(); exp_cyc("to_done", 0, 0, 1); adv();
    idle_ex();
    settle(); exp_cyc("to_idle", 0, 0, 0); adv();
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h55;
    settle(); exp_cyc("to_stray", 0, 0, 0); adv();
    bus.dmem_rvalid = 1'b0; bus.dmem_rdata = '0;

    // Reset while waiting for the response aborts the access
    drive_ex(32'h5000, F3_W, 5'd3, 1'b1, 1'b0, 1'b1, 32'h300, 32'h0);
    bus.dmem_ready = 1'b1;
    settle(); exp_cyc("rs_c0", 1, 1, 0); adv();
    bus.dmem_ready = 1'b0; reset = 1'b1;
    settle(); exp_cyc("rs_c1", 1, 0, 0); adv();
    reset = 1'b0; idle_ex();
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h12345678;
    settle(); exp_cyc("rs_c2", 0, 0, 0); adv();
    bus.dmem_rvalid = 1'b0; bus.dmem_rdata = '0;
    drive_ex(32'h5004, 3'b000, 5'd7, 1'b0, 1'b0, 1'b1, 32'h44, 32'h0);
    sb_q.push_back('{32'h5004, mk_instr(3'b000), 32'h44, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0});
    settle(); exp_cyc("rs_alu", 0, 0, 1); adv();
    idle_ex();
    settle(); exp_cyc("final_idle", 0, 0, 0); adv();

    chk("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage_v.md
Name: mem_stage_v

Overview:
- Pipeline MEM stage between the EX/MEM register and the MEM/WB register.
- Passes ALU-only instructions straight through in the same cycle.
- For loads and stores, drives a variable-latency data-memory bus through a request/ready/rvalid handshake and stalls upstream until the access completes.
- Byte/half lane alignment, load sign/zero extension, misalignment detection and a watchdog timeout are handled here.

Parameters:
TIMEOUT_CYCLES, 255, max cycles spent in REQ+WAIT before the access is abandoned with error (range 1..65535).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ex_isValid  in  1  EX/MEM slot holds a real instruction
ex_pc  in  32  instruction PC
ex_instr  in  32  instruction word; funct3 = instr[14:12]
ex_rd  in  5  destination register
ex_mem_read  in  1  load
ex_mem_write  in  1  store
ex_reg_write  in  1  writes rd
ex_aluResult  in  32  effective address / ALU result
ex_storeData  in  32  store source (rs2)
mem_stall  out  1  hold EX/MEM and all earlier stages
dmem_req  out  1  bus request
dmem_we  out  1  1=write
dmem_addr  out  32  word-aligned address ({alu[31:2],2'b00})
dmem_wdata  out  32  lane-replicated store data
dmem_be  out  4  byte enables
dmem_ready  in  1  request accepted this cycle
dmem_rvalid  in  1  response (read data or write ack)
dmem_rdata  in  32  read data
mem_isValid  out  1  completion strobe to MEM/WB
mem_pc, mem_instr  out  32 each  forwarded
mem_rd  out  5  forwarded
mem_mem_read, mem_mem_write  out  1 each  forwarded
mem_reg_write  out  1  forwarded; forced 0 on error
mem_aluResult  out  32  forwarded
mem_memResult  out  32  extended load data; 0 for non-loads
mem_err  out  1  misaligned, illegal funct3 or timeout

Behaviour:
- States: IDLE, REQ, WAIT, DONE.
- Reset: state IDLE; all latches and timeout counter zero. mem_stall, dmem_req and mem_isValid are 0. All other outputs are 0.
- Outputs are combinational from state, latches and the IDLE inputs.
- IDLE, no ex_isValid: mem_isValid=0, no request.
- IDLE, ex_isValid with mem_read=mem_write=0: same-cycle pass-through. mem_isValid=1, memResult=0, err=0, stall=0.
- IDLE, memory op with bad alignment (half: addr[0]=1; word: addr[1:0]!=0) or illegal funct3:
  - no bus request; same-cycle completion with err=1, reg_write=0, memResult=0, stall=0.
  - Legal loads: LB 000, LH 001, LW 010, LBU 100, LHU 101. Legal stores: SB, SH, SW.
- IDLE, legal memory op:
  - stall=1 and dmem_req=1 combinationally; latch all ex_* fields.
  - Next state is WAIT if dmem_ready=1, else REQ.
- REQ: dmem_req=1 with addr/we/wdata/be held constant from the latch until dmem_ready; then go to WAIT. stall=1.
- WAIT: dmem_req=0, stall=1. On dmem_rvalid, capture extended rdata (loads) and go to DONE.
- rvalid is never earlier than the cycle after acceptance; rvalid in IDLE/REQ/DONE is ignored.
- DONE, exactly 1 cycle: mem_isValid=1 with outputs from the latch, stall=0. Upstream advances at this edge. ex_* inputs are ignored in DONE. Next state is IDLE.
- Timeout:
  - Counter clears on leaving IDLE and increments each REQ/WAIT cycle.
  - When it reaches TIMEOUT_CYCLES, drop dmem_req and go to DONE with err=1, reg_write=0, memResult=32'hDEADBEEF.
  - A later stray rvalid is ignored.
- Store lanes:
  - SB: wdata={4{sd[7:0]}}, be=4'b0001<<addr[1:0].
  - SH: wdata={2{sd[15:0]}}, be=addr[1]?1100:0011.
  - SW: be=1111.
- Load extract:
  - byte = rdata lane addr[1:0]; half = lane addr[1].
  - LB/LH sign-extend, LBU/LHU zero-extend.
- Reset mid-operation: immediate return to IDLE, dmem_req=0 next cycle, no mem_isValid for the aborted access.
- Best-case load/store latency: 3 cycles (IDLE accept, WAIT rvalid, DONE).

Decomposition:
- Shared package:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - state encoding.
  - MEM_ERR_DATA=32'hDEADBEEF.
- One sub-module, mem_align_v (combinational):
  - store wdata/be generation.
  - load extract/extend.
  - misalignment/illegal flag.

Test Plan:
1. ALU op, alu=0x10, rd=5, reg_write=1 -> mem_isValid same cycle, mem_aluResult=0x10, memResult=0, stall=0, dmem_req never high.
2. LB addr 0x103, ready in cycle 0, rvalid in cycle 1 with rdata 0x80FFFFFF -> stall high cycles 0-1, memResult=0xFFFFFF80, mem_isValid in cycle 2 only. Repeat with LBU -> 0x00000080.
3. SH addr 0x102, sd 0x1234ABCD, ready delayed 2 cycles -> req/addr 0x100/we=1/wdata 0xABCDABCD/be 1100 stable 3 cycles. Ack completes with memResult=0, err=0.
4. LW addr 0x101 -> no req, same-cycle mem_isValid, err=1, reg_write=0, stall=0.
5. TIMEOUT_CYCLES=4, accepted load, no rvalid -> completion after 4 REQ/WAIT cycles, err=1, memResult=0xDEADBEEF. Rvalid injected 2 cycles later is ignored.
6. Reset asserted in WAIT, stale rvalid the next cycle -> state IDLE, dmem_req=0, no mem_isValid. A following ALU op passes through normally.
